// File: rtl/fetch_pkg.sv
// Shared fetch-path types and Sysbus tag constants for the instruction line fetcher.
package fetch_pkg;

    typedef enum logic [2:0] {IDLE, REQ, RECV, DONE, DRAIN} lf_state_t;

    // Sysbus tag prefix fields: read command, memory space.
    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
    localparam logic [4:0] READ_MEM_TAG  = {SYSBUS_READ, SYSBUS_MEMORY};

endpackage

// File: rtl/imem_line_fetcher.sv
// Instruction-fetch bus master: one aligned SYSBUS_READ per request, LINE_BEATS
// response beats assembled into a line, handed out over valid/ready; redirect flush drains.
module imem_line_fetcher
    import fetch_pkg::*;
#(
    parameter int         BUS_DATA_WIDTH = 64,
    parameter int         BUS_TAG_WIDTH  = 13,
    parameter int         LINE_BEATS     = 8,
    parameter logic [7:0] TAG_ID         = 8'h00,
    localparam int        LINE_W         = BUS_DATA_WIDTH * LINE_BEATS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [63:0]               req_addr,
    input  logic                      flush,
    output logic                      line_valid,
    input  logic                      line_ready,
    output logic [LINE_W-1:0]         line_data,
    output logic [63:0]               line_addr,
    output logic                      busy,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int            OFS  = $clog2(LINE_W / 8);
    localparam int            CW   = $clog2(LINE_BEATS);
    localparam logic [CW-1:0] LAST = CW'(LINE_BEATS - 1);

    lf_state_t     state;
    logic [CW-1:0] cnt;
    logic          flush_seen;
    logic [63:0]   aligned_addr;
    logic          accept;

    // Only one request is ever outstanding, so the response tag carries no information.
    logic unused_inputs;
    assign unused_inputs = ^{bus_resptag, req_addr[OFS-1:0]};

    assign aligned_addr = {req_addr[63:OFS], {OFS{1'b0}}};
    assign req_ready    = (state == IDLE) & ~flush;
    assign accept       = req_valid & req_ready;
    assign busy         = (state != IDLE);
    assign bus_respack  = bus_respcyc & ((state == RECV) | (state == DRAIN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_seen <= 1'b0;
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
            line_valid <= 1'b0;
            line_data  <= '0;
            line_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_req    <= BUS_DATA_WIDTH'(aligned_addr);
                        line_addr  <= aligned_addr;
                        bus_reqtag <= BUS_TAG_WIDTH'({READ_MEM_TAG, TAG_ID});
                        bus_reqcyc <= 1'b1;
                        flush_seen <= 1'b0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // The read cannot be withdrawn once strobed; a flush here only
                    // turns the coming burst into a drain.
                    if (bus_reqack) begin
                        bus_reqcyc <= 1'b0;
                        flush_seen <= 1'b0;
                        state      <= (flush_seen | flush) ? DRAIN : RECV;
                    end else if (flush) begin
                        flush_seen <= 1'b1;
                    end
                end
                RECV: begin
                    if (bus_respcyc) begin
                        cnt <= cnt + 1'b1;
                        if (!flush)
                            line_data[cnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
                        if (cnt == LAST) begin
                            state      <= flush ? IDLE : DONE;
                            line_valid <= ~flush;
                        end else if (flush) begin
                            state <= DRAIN;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    if (flush || line_ready) begin
                        line_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                DRAIN: begin
                    if (bus_respcyc) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_line_fetcher.sv
// Directed bench for imem_line_fetcher: table-driven basic fetch plus hand sequences
// for reset, backpressure, gapped bursts and flush in REQ/RECV/DONE.
module tb_imem_line_fetcher;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int LB = 8;
    localparam int LW = DW * LB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid, req_ready, flush, line_valid, line_ready, busy;
    logic [63:0]   req_addr, line_addr;
    logic [LW-1:0] line_data;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [DW-1:0] bus_req, bus_resp;
    logic [TW-1:0] bus_reqtag, bus_resptag;

    int n_vec = 0;
    int n_bad = 0;

    imem_line_fetcher #(
        .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .LINE_BEATS(LB), .TAG_ID(8'h00)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .line_valid(line_valid), .line_ready(line_ready),
        .line_data(line_data), .line_addr(line_addr),
        .busy(busy),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [63:0] addr;
        logic        ack;
        logic        rc;
        logic [63:0] resp;
        logic        lr;
        logic        e_rr, e_busy, e_rqc, e_rpa, e_lv;
        logic        chk_line;
        logic [63:0] e_lo, e_hi;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [63:0] beat(input int i);
        return line_data[i*DW +: DW];
    endfunction

    task automatic idle_in();
        req_valid = 1'b0; req_addr = 64'h0; flush = 1'b0; line_ready = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    endtask

    task automatic issue(input logic [63:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        settle();
        chk("issue_req_ready", 64'(req_ready), 64'd1);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic grant(input int wait_n);
        for (int k = 0; k < wait_n; k++) begin
            settle();
            chk("reqcyc_wait", 64'(bus_reqcyc), 64'd1);
            cyc();
        end
        bus_reqack = 1'b1;
        settle();
        chk("reqcyc_ack", 64'(bus_reqcyc), 64'd1);
        cyc();
        bus_reqack = 1'b0;
    endtask

    task automatic beats(input int first, input int last, input logic [63:0] base);
        for (int k = first; k <= last; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(k);
            settle();
            chk("beat_respack", 64'(bus_respack), 64'd1);
            chk("beat_line_valid", 64'(line_valid), 64'd0);
            cyc();
        end
        bus_respcyc = 1'b0;
    endtask

    initial begin
        idle_in();

        // Basic fetch at 0x1234: ack after 2 wait cycles, beats 0x10..0x17.
        tbl[0]  = '{1'b1, 64'h1234, 1'b0, 1'b0, 64'h0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
        tbl[1]  = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[3].ack = 1'b1;
        for (int i = 0; i < LB; i++)
            tbl[4+i] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h10 + 64'(i), 1'b0,
                         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0};
        tbl[12] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h10, 64'h17};
        tbl[13] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};

        // Reset state
        settle();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("rst_line_valid", 64'(line_valid), 64'd0);
        chk("rst_bus_req", bus_req, 64'd0);
        cyc();
        reset = 1'b1;
        cyc();

        for (int i = 0; i < 14; i++) begin
            req_valid   = tbl[i].rv;
            req_addr    = tbl[i].addr;
            bus_reqack  = tbl[i].ack;
            bus_respcyc = tbl[i].rc;
            bus_resp    = tbl[i].resp;
            line_ready  = tbl[i].lr;
            settle();
            chk($sformatf("t%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].e_rr));
            chk($sformatf("t%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("t%0d_reqcyc", i), 64'(bus_reqcyc), 64'(tbl[i].e_rqc));
            chk($sformatf("t%0d_respack", i), 64'(bus_respack), 64'(tbl[i].e_rpa));
            chk($sformatf("t%0d_line_valid", i), 64'(line_valid), 64'(tbl[i].e_lv));
            if (tbl[i].e_rqc) begin
                chk($sformatf("t%0d_bus_req", i), bus_req, 64'h1200);
                chk($sformatf("t%0d_bus_reqtag", i), 64'(bus_reqtag), 64'h1100);
            end
            if (tbl[i].chk_line) begin
                chk($sformatf("t%0d_beat0", i), beat(0), tbl[i].e_lo);
                chk($sformatf("t%0d_beat7", i), beat(7), tbl[i].e_hi);
                chk($sformatf("t%0d_line_addr", i), line_addr, 64'h1200);
            end
            cyc();
        end
        idle_in();

        // Async reset while beat 3 is on the bus
        issue(64'h200);
        grant(0);
        beats(0, 2, 64'h70);
        bus_respcyc = 1'b1;
        bus_resp    = 64'h73;
        reset       = 1'b0;
        settle();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_respack", 64'(bus_respack), 64'd0);
        chk("mid_rst_reqtag", 64'(bus_reqtag), 64'd0);
        chk("mid_rst_line_addr", line_addr, 64'd0);
        chk("mid_rst_line_data", 64'(|line_data), 64'd0);
        chk("mid_rst_bus_req", bus_req, 64'd0);
        cyc();
        bus_respcyc = 1'b0;
        reset       = 1'b1;
        settle();
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        cyc();

        // Consumer backpressure for 5 cycles, next request queued behind it
        issue(64'h40);
        settle();
        chk("bp_bus_req", bus_req, 64'h40);
        grant(0);
        beats(0, 7, 64'h20);
        req_valid = 1'b1;
        req_addr  = 64'h80;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("bp_line_valid", 64'(line_valid), 64'd1);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_beat0", beat(0), 64'h20);
            chk("bp_beat7", beat(7), 64'h27);
            chk("bp_line_addr", line_addr, 64'h40);
            cyc();
        end
        line_ready = 1'b1;
        settle();
        chk("bp_hs_req_ready", 64'(req_ready), 64'd0);
        cyc();
        line_ready = 1'b0;
        settle();
        chk("bp_next_req_ready", 64'(req_ready), 64'd1);
        chk("bp_next_line_valid", 64'(line_valid), 64'd0);
        cyc();
        req_valid = 1'b0;
        settle();
        chk("bp_next_reqcyc", 64'(bus_reqcyc), 64'd1);
        chk("bp_next_bus_req", bus_req, 64'h80);

        // Gapped burst: 3 idle cycles between beats 4 and 5
        grant(1);
        beats(0, 4, 64'h30);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("gap_respack", 64'(bus_respack), 64'd0);
            chk("gap_busy", 64'(busy), 64'd1);
            cyc();
        end
        beats(5, 7, 64'h30);
        settle();
        chk("gap_line_valid", 64'(line_valid), 64'd1);
        chk("gap_beat4", beat(4), 64'h34);
        chk("gap_beat5", beat(5), 64'h35);
        chk("gap_beat7", beat(7), 64'h37);
        chk("gap_line_addr", line_addr, 64'h80);
        line_ready = 1'b1;
        cyc();
        line_ready = 1'b0;

        // Flush in REQ: strobe stays up until ack, whole burst drained
        issue(64'hC0);
        flush = 1'b1;
        settle();
        chk("freq_reqcyc0", 64'(bus_reqcyc), 64'd1);
        cyc();
        flush = 1'b0;
        settle();
        chk("freq_reqcyc1", 64'(bus_reqcyc), 64'd1);
        cyc();
        grant(0);
        beats(0, 7, 64'h90);
        settle();
        chk("freq_busy", 64'(busy), 64'd0);
        chk("freq_line_valid", 64'(line_valid), 64'd0);
        chk("freq_req_ready", 64'(req_ready), 64'd1);
        chk("freq_beat0_kept", beat(0), 64'h30);
        cyc();

        // Flush in DONE alongside line_ready: line dropped
        issue(64'h100);
        grant(0);
        beats(0, 7, 64'h50);
        line_ready = 1'b1;
        flush      = 1'b1;
        settle();
        chk("fdone_line_valid", 64'(line_valid), 64'd1);
        chk("fdone_req_ready", 64'(req_ready), 64'd0);
        cyc();
        line_ready = 1'b0;
        flush      = 1'b0;
        settle();
        chk("fdone_after_valid", 64'(line_valid), 64'd0);
        chk("fdone_after_busy", 64'(busy), 64'd0);
        cyc();

        // Flush in RECV at beat 5: beats 5..7 acked, not written
        issue(64'h140);
        grant(0);
        beats(0, 4, 64'h60);
        flush       = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = 64'h65;
        settle();
        chk("frecv_respack5", 64'(bus_respack), 64'd1);
        cyc();
        flush = 1'b0;
        beats(6, 7, 64'h60);
        settle();
        chk("frecv_busy", 64'(busy), 64'd0);
        chk("frecv_line_valid", 64'(line_valid), 64'd0);
        chk("frecv_beat5_kept", beat(5), 64'h55);
        chk("frecv_beat6_kept", beat(6), 64'h56);

        // Stray response beat while idle is not acked
        bus_respcyc = 1'b1;
        settle();
        chk("idle_respack", 64'(bus_respack), 64'd0);
        cyc();
        bus_respcyc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
